uart_mmio_bridge: RTL and testbench

Memory-side splitter between `custom_cpu`'s data-memory port and the memory interface wrapper. Requests with `Address[31:16] == 16'h6000` are served locally by a UART-Lite-style register file: a TX FIFO, a one-entry RX holding register, status and control. All other requests pass through unchanged to the downstream memory port. It replaces the ad-hoc UART decode glue in the test tops with one handshake-correct block.

---
 rtl/uart_mmio_bridge_if.sv | 22 ++
 rtl/uart_mmio_bridge.sv | 173 +++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_bridge_if.sv
// rtl/uart_mmio_bridge_if.sv - CPU data-memory request/response bus
interface uart_mmio_bridge_if;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    modport master (
        output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - splits CPU data requests between a UART-Lite register file and memory
module uart_mmio_bridge #(
    parameter int          TX_DEPTH  = 16,
    parameter logic [15:0] UART_BASE = 16'h6000
) (
    input  logic                cpu_clk,
    input  logic                cpu_reset_n,
    uart_mmio_bridge_if.slave   cpu,
    output logic [31:0]         m_Address,
    output logic                m_MemWrite,
    output logic [31:0]         m_Write_data,
    output logic [3:0]          m_Write_strb,
    output logic                m_MemRead,
    input  logic                m_Mem_Req_Ready,
    input  logic [31:0]         m_Read_data,
    input  logic                m_Read_data_Valid,
    output logic                m_Read_data_Ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready
);
    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, PASS_RD, LOC_RD} state_t;

    state_t      state;
    logic [7:0]  fifo [TX_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        rx_full;
    logic [7:0]  rx_byte;
    logic [31:0] rd_reg;

    logic        sel;
    logic [3:0]  offset;
    logic        idle;
    logic        tx_empty;
    logic        tx_full;
    logic        loc_rd;
    logic        loc_wr_req;
    logic        push_req;
    logic        loc_wr;
    logic        push;
    logic        pop;
    logic        ctrl_wr;
    logic        flush;
    logic        rx_clr_ctrl;
    logic        rx_clr_rd;
    logic        rx_acc;
    logic [31:0] stat;
    logic [31:0] rd_mux;

    assign sel         = (cpu.Address[31:16] == UART_BASE);
    assign offset      = cpu.Address[3:0];
    assign idle        = (state == IDLE);
    assign tx_empty    = (wr_ptr == rd_ptr);
    assign tx_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A simultaneous read and write is treated as a read.
    assign loc_rd      = idle & sel & cpu.MemRead;
    assign loc_wr_req  = idle & sel & cpu.MemWrite & ~cpu.MemRead;
    assign push_req    = loc_wr_req & (offset == 4'h4) & cpu.Write_strb[0];
    // A TX push into a full FIFO is held off rather than dropped.
    assign loc_wr      = loc_wr_req & ~(push_req & tx_full);
    assign push        = push_req & ~tx_full;
    assign pop         = ~tx_empty & tx_ready;
    assign ctrl_wr     = loc_wr & (offset == 4'hC) & cpu.Write_strb[0];
    assign flush       = ctrl_wr & cpu.Write_data[0];
    assign rx_clr_ctrl = ctrl_wr & cpu.Write_data[1];
    assign rx_clr_rd   = loc_rd & (offset == 4'h0);
    assign rx_acc      = rx_valid & ~rx_full;
    assign stat        = {28'b0, tx_full, tx_empty, 1'b0, rx_full};

    // Local read data selected by offset, captured into rd_reg at accept.
    always_comb begin
        rd_mux = 32'b0;
        case (offset)
            4'h0:    rd_mux = {24'b0, rx_byte};
            4'h8:    rd_mux = stat;
            default: rd_mux = 32'b0;
        endcase
    end

    assign m_Address    = cpu.Address;
    assign m_Write_data = cpu.Write_data;
    assign m_Write_strb = cpu.Write_strb;
    assign m_MemRead    = idle & cpu.MemRead & ~sel;
    assign m_MemWrite   = idle & cpu.MemWrite & ~sel;

    assign cpu.Mem_Req_Ready = idle & (sel ? (loc_rd | loc_wr) : m_Mem_Req_Ready);

    // Response path follows the active read state; nothing is returned in IDLE.
    always_comb begin
        cpu.Read_data       = 32'b0;
        cpu.Read_data_Valid = 1'b0;
        m_Read_data_Ready   = 1'b0;
        case (state)
            PASS_RD: begin
                cpu.Read_data       = m_Read_data;
                cpu.Read_data_Valid = m_Read_data_Valid;
                m_Read_data_Ready   = cpu.Read_data_Ready;
            end
            LOC_RD: begin
                cpu.Read_data       = rd_reg;
                cpu.Read_data_Valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_valid = ~tx_empty;
    assign tx_data  = fifo[rd_ptr[AW-1:0]];
    assign rx_ready = ~rx_full;

    // Request/response FSM and local read-data latch.
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state  <= IDLE;
            rd_reg <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu.MemRead && !sel && m_Mem_Req_Ready) begin
                        state <= PASS_RD;
                    end else if (loc_rd) begin
                        state  <= LOC_RD;
                        rd_reg <= rd_mux;
                    end
                end
                PASS_RD: if (m_Read_data_Valid && cpu.Read_data_Ready) state <= IDLE;
                LOC_RD:  if (cpu.Read_data_Ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // TX FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge cpu_clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= cpu.Write_data[7:0];
    end

    // TX FIFO pointers; a flush overrides any concurrent push or pop.
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // RX holding register; a CTRL clear beats an incoming byte, and an
    // incoming byte can only arrive while empty so it beats a read clear.
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            rx_full <= 1'b0;
            rx_byte <= 8'b0;
        end else if (rx_clr_ctrl) begin
            rx_full <= 1'b0;
        end else if (rx_acc) begin
            rx_full <= 1'b1;
            rx_byte <= rx_data;
        end else if (rx_clr_rd) begin
            rx_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - directed self-checking bench for uart_mmio_bridge
module tb_uart_mmio_bridge;
    logic        cpu_clk;
    logic        cpu_reset_n;
    logic [31:0] m_Address;
    logic        m_MemWrite;
    logic [31:0] m_Write_data;
    logic [3:0]  m_Write_strb;
    logic        m_MemRead;
    logic        m_Mem_Req_Ready;
    logic [31:0] m_Read_data;
    logic        m_Read_data_Valid;
    logic        m_Read_data_Ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;

    uart_mmio_bridge_if bus();

    uart_mmio_bridge #(.TX_DEPTH(16), .UART_BASE(16'h6000)) dut (
        .cpu_clk           (cpu_clk),
        .cpu_reset_n       (cpu_reset_n),
        .cpu               (bus),
        .m_Address         (m_Address),
        .m_MemWrite        (m_MemWrite),
        .m_Write_data      (m_Write_data),
        .m_Write_strb      (m_Write_strb),
        .m_MemRead         (m_MemRead),
        .m_Mem_Req_Ready   (m_Mem_Req_Ready),
        .m_Read_data       (m_Read_data),
        .m_Read_data_Valid (m_Read_data_Valid),
        .m_Read_data_Ready (m_Read_data_Ready),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat);
        @(posedge cpu_clk); #1;
        bus.Address = a; bus.Write_data = d; bus.Write_strb = s; bus.MemWrite = 1'b1;
        lat = 0;
        forever begin
            @(negedge cpu_clk);
            if (bus.Mem_Req_Ready) break;
            lat++;
            if (lat > 64) begin
                checks++; errors++;
                $display("FAIL write_timeout addr=%h got no ready want ready", a);
                break;
            end
        end
        @(posedge cpu_clk); #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        int n;
        @(posedge cpu_clk); #1;
        bus.Address = a; bus.MemRead = 1'b1;
        n = 0;
        forever begin
            @(negedge cpu_clk);
            if (bus.Mem_Req_Ready) break;
            n++;
            if (n > 64) begin
                checks++; errors++;
                $display("FAIL read_req_timeout addr=%h got no ready want ready", a);
                break;
            end
        end
        @(posedge cpu_clk); #1;
        bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b1;
        lat = 0;
        forever begin
            @(negedge cpu_clk);
            if (bus.Read_data_Valid) break;
            lat++;
            if (lat > 64) begin
                checks++; errors++;
                $display("FAIL read_rsp_timeout addr=%h got no valid want valid", a);
                break;
            end
        end
        d = bus.Read_data;
        @(posedge cpu_clk); #1;
        bus.Read_data_Ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", bus.Mem_Req_Ready); end
        checks++; if (bus.Read_data_Valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", bus.Read_data_Valid); end
        checks++; if (bus.Read_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got %h want 0", bus.Read_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %b want 1", rx_ready); end
        checks++; if ({m_MemRead, m_MemWrite} !== 2'b00) begin errors++; $display("FAIL rst_m_strobes got %b want 00", {m_MemRead, m_MemWrite}); end
    endtask

    task automatic test_tx_single;
        int lat; logic [31:0] d;
        tx_ready = 1'b0;
        cpu_write(32'h6000_0004, 32'h0000_0041, 4'hF, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL tx1_accept_lat got %0d want 0", lat); end
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx1_stat_queued got %h want 0", d); end
        @(posedge cpu_clk); #1; tx_ready = 1'b1;
        @(negedge cpu_clk);
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin errors++; $display("FAIL tx1_beat got %b/%h want 1/41", tx_valid, tx_data); end
        @(posedge cpu_clk); #1; tx_ready = 1'b0;
        @(negedge cpu_clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx1_after_pop got %b want 0", tx_valid); end
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL tx1_stat_empty got %h want 4", d); end
    endtask

    task automatic test_tx_full;
        int lat; logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) cpu_write(32'h6000_0004, 32'h10 + i, 4'hF, lat);
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL full_stat got %h want 8", d); end
        @(posedge cpu_clk); #1;
        bus.Address = 32'h6000_0004; bus.Write_data = 32'h20; bus.Write_strb = 4'hF; bus.MemWrite = 1'b1;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", bus.Mem_Req_Ready); end
        @(posedge cpu_clk); #1; tx_ready = 1'b1;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b0) begin errors++; $display("FAIL full_stall2 got %b want 0", bus.Mem_Req_Ready); end
        checks++; if (tx_data !== 8'h10) begin errors++; $display("FAIL full_head got %h want 10", tx_data); end
        @(posedge cpu_clk); #1; tx_ready = 1'b0;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b1) begin errors++; $display("FAIL full_release got %b want 1", bus.Mem_Req_Ready); end
        @(posedge cpu_clk); #1; bus.MemWrite = 1'b0;
        @(posedge cpu_clk); #1; tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge cpu_clk);
            checks++;
            if ({tx_valid, tx_data} !== {1'b1, 8'(8'h11 + k)}) begin
                errors++; $display("FAIL drain_%0d got %b/%h want 1/%h", k, tx_valid, tx_data, 8'(8'h11 + k));
            end
            @(posedge cpu_clk);
        end
        #1; tx_ready = 1'b0;
        @(negedge cpu_clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_rx;
        int lat; logic [31:0] d;
        @(posedge cpu_clk); #1; rx_valid = 1'b1; rx_data = 8'h5A;
        @(negedge cpu_clk);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_before got %b want 1", rx_ready); end
        @(posedge cpu_clk); #1; rx_valid = 1'b0;
        @(negedge cpu_clk);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got %b want 0", rx_ready); end
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL rx_stat_full got %h want 5", d); end
        cpu_read(32'h6000_0000, d, lat);
        checks++; if (d !== 32'h5A) begin errors++; $display("FAIL rx_data got %h want 5a", d); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL rx_rsp_lat got %0d want 0", lat); end
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL rx_stat_cleared got %h want 4", d); end
        @(posedge cpu_clk); #1; rx_valid = 1'b1; rx_data = 8'h77;
        @(posedge cpu_clk); #1; rx_valid = 1'b0;
        cpu_write(32'h6000_000C, 32'h2, 4'hF, lat);
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL rx_ctrl_clear got %h want 4", d); end
    endtask

    task automatic test_pass;
        int lat; logic [31:0] d;
        @(posedge cpu_clk); #1;
        bus.Address = 32'h0000_1000; bus.MemRead = 1'b1; m_Mem_Req_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            checks++;
            if ({m_MemRead, m_Address, bus.Mem_Req_Ready} !== {1'b1, 32'h0000_1000, 1'b0}) begin
                errors++; $display("FAIL pass_wait_%0d got %b/%h/%b want 1/00001000/0", i, m_MemRead, m_Address, bus.Mem_Req_Ready);
            end
            @(posedge cpu_clk); #1;
        end
        m_Mem_Req_Ready = 1'b1;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b1) begin errors++; $display("FAIL pass_accept got %b want 1", bus.Mem_Req_Ready); end
        @(posedge cpu_clk); #1;
        bus.MemRead = 1'b0; m_Mem_Req_Ready = 1'b0; bus.Read_data_Ready = 1'b0;
        m_Read_data = 32'hDEAD_BEEF; m_Read_data_Valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge cpu_clk);
            checks++;
            if ({bus.Read_data_Valid, bus.Read_data, m_Read_data_Ready, bus.Mem_Req_Ready} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
                errors++; $display("FAIL pass_stall_%0d got %b/%h/%b/%b want 1/deadbeef/0/0", i, bus.Read_data_Valid, bus.Read_data, m_Read_data_Ready, bus.Mem_Req_Ready);
            end
            @(posedge cpu_clk); #1;
        end
        bus.Read_data_Ready = 1'b1;
        @(negedge cpu_clk);
        checks++; if (m_Read_data_Ready !== 1'b1) begin errors++; $display("FAIL pass_ready_mirror got %b want 1", m_Read_data_Ready); end
        @(posedge cpu_clk); #1;
        bus.Read_data_Ready = 1'b0; m_Read_data_Valid = 1'b0;
        @(negedge cpu_clk);
        checks++; if (bus.Read_data_Valid !== 1'b0) begin errors++; $display("FAIL pass_done got %b want 0", bus.Read_data_Valid); end
        @(posedge cpu_clk); #1;
        bus.Address = 32'h0000_2000; bus.Write_data = 32'h1234_5678; bus.Write_strb = 4'h3;
        bus.MemWrite = 1'b1; m_Mem_Req_Ready = 1'b1;
        @(negedge cpu_clk);
        checks++;
        if ({m_MemWrite, m_Write_data, m_Write_strb, bus.Mem_Req_Ready} !== {1'b1, 32'h1234_5678, 4'h3, 1'b1}) begin
            errors++; $display("FAIL pass_write got %b/%h/%h/%b want 1/12345678/3/1", m_MemWrite, m_Write_data, m_Write_strb, bus.Mem_Req_Ready);
        end
        @(posedge cpu_clk); #1;
        bus.MemWrite = 1'b0; m_Mem_Req_Ready = 1'b0;
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL pass_uart_untouched got %h want 4", d); end
    endtask

    task automatic test_flush;
        int lat; logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(32'h6000_0004, 32'hA1 + i, 4'hF, lat);
        @(posedge cpu_clk); #1;
        bus.Address = 32'h6000_000C; bus.Write_data = 32'h1; bus.Write_strb = 4'hF; bus.MemWrite = 1'b1;
        tx_ready = 1'b1;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b1) begin errors++; $display("FAIL flush_accept got %b want 1", bus.Mem_Req_Ready); end
        @(posedge cpu_clk); #1;
        bus.MemWrite = 1'b0; tx_ready = 1'b0;
        @(negedge cpu_clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", tx_valid); end
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL flush_stat got %h want 4", d); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] d;
        tx_ready = 1'b0;
        cpu_write(32'h6000_0004, 32'h55, 4'hF, lat);
        @(posedge cpu_clk); #1; rx_valid = 1'b1; rx_data = 8'h99;
        @(posedge cpu_clk); #1; rx_valid = 1'b0;
        bus.Address = 32'h6000_0008; bus.MemRead = 1'b1; bus.Read_data_Ready = 1'b0;
        @(negedge cpu_clk);
        checks++; if (bus.Mem_Req_Ready !== 1'b1) begin errors++; $display("FAIL rmid_accept got %b want 1", bus.Mem_Req_Ready); end
        @(posedge cpu_clk); #1; bus.MemRead = 1'b0;
        @(negedge cpu_clk);
        checks++; if ({bus.Read_data_Valid, bus.Read_data} !== {1'b1, 32'h1}) begin errors++; $display("FAIL rmid_pending got %b/%h want 1/1", bus.Read_data_Valid, bus.Read_data); end
        #2; cpu_reset_n = 1'b0;
        #1;
        checks++; if (bus.Read_data_Valid !== 1'b0) begin errors++; $display("FAIL rmid_drop got %b want 0", bus.Read_data_Valid); end
        checks++; if ({tx_valid, rx_ready} !== 2'b01) begin errors++; $display("FAIL rmid_uart got %b want 01", {tx_valid, rx_ready}); end
        @(posedge cpu_clk); #1; cpu_reset_n = 1'b1;
        cpu_read(32'h6000_0008, d, lat);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL rmid_stat got %h want 4", d); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rmid_rx_ready got %b want 1", rx_ready); end
    endtask

    initial begin
        cpu_reset_n = 1'b0;
        bus.Address = 32'h0; bus.MemWrite = 1'b0; bus.Write_data = 32'h0; bus.Write_strb = 4'h0;
        bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b0;
        m_Mem_Req_Ready = 1'b0; m_Read_data = 32'h0; m_Read_data_Valid = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        repeat (3) @(posedge cpu_clk);
        #1; cpu_reset_n = 1'b1;
        test_reset;
        test_tx_single;
        test_tx_full;
        test_rx;
        test_pass;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
